pipelined_pg_addsub: RTL and testbench

Parametrised, pipelined adder/subtractor built from per-bit sum/propagate/generate (SPG) cells feeding a parallel-prefix carry network. It replaces chains of single-bit precharged SPG cells in the datapath with a WIDTH-bit, three-stage registered unit that has a valid/ready handshake, per-transaction add/subtract select and signed-overflow/carry flags. It sits between operand registers and the ALU result mux.

---
 rtl/addsub_pkg.sv | 32 +++
 rtl/pg_prefix_tree.sv | 40 ++++
 rtl/pipelined_pg_addsub.sv | 109 ++++++++++
 tb/tb_pipelined_pg_addsub.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and helpers for pipelined_pg_addsub.
//   pg_t          - per-position propagate/generate pair
//   clog2_levels  - Kogge-Stone level count for a WIDTH-bit adder with carry-in
//   SAT_POS/NEG   - signed saturation limits for a given width (LSB-aligned)
package addsub_pkg;

   localparam int unsigned MAX_WIDTH = 64;

   typedef struct packed {
      logic p;
      logic g;
   } pg_t;

   // The carry-in occupies an extra prefix position, so the tree spans width+1 nodes.
   function automatic int unsigned clog2_levels(input int unsigned width);
      int unsigned lv;
      lv = 0;
      while ((32'd1 << lv) < (width + 32'd1)) lv = lv + 32'd1;
      return lv;
   endfunction

   // Largest positive two's-complement value: 0111...1
   function automatic logic [MAX_WIDTH-1:0] SAT_POS(input int unsigned width);
      return (MAX_WIDTH'(1) << (width - 32'd1)) - MAX_WIDTH'(1);
   endfunction

   // Most negative two's-complement value: 1000...0
   function automatic logic [MAX_WIDTH-1:0] SAT_NEG(input int unsigned width);
      return MAX_WIDTH'(1) << (width - 32'd1);
   endfunction

endpackage

// File: rtl/pg_prefix_tree.sv
// pg_prefix_tree: combinational Kogge-Stone carry network.
//   g, p  - per-bit generate/propagate, bit 0 = LSB
//   cin   - carry into bit 0, treated as a generate at position -1
//   carry - carry[i] is the carry into bit i (carry[WIDTH] = carry out)
module pg_prefix_tree
   import addsub_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] g,
   input  logic [WIDTH-1:0] p,
   input  logic             cin,
   output logic [WIDTH:1]   carry
);

   localparam int unsigned LEVELS = clog2_levels(WIDTH);

   // node[0] is the carry-in; node[i] is bit i-1. Spans need not be a power of two:
   // nodes whose look-back falls below position 0 simply pass through.
   pg_t node [WIDTH+1];
   pg_t prev [WIDTH+1];

   always_comb begin
      node[0] = '{p: 1'b0, g: cin};
      for (int i = 1; i <= int'(WIDTH); i++) node[i] = '{p: p[i-1], g: g[i-1]};
      prev = node;
      for (int lv = 0; lv < int'(LEVELS); lv++) begin
         prev = node;
         for (int i = 0; i <= int'(WIDTH); i++) begin
            if (i >= (1 << lv)) begin
               node[i].g = prev[i].g | (prev[i].p & prev[i - (1 << lv)].g);
               node[i].p = prev[i].p & prev[i - (1 << lv)].p;
            end
         end
      end
      carry = '0;
      for (int i = 1; i <= int'(WIDTH); i++) carry[i] = node[i].g;
   end

endmodule

// File: rtl/pipelined_pg_addsub.sv
// pipelined_pg_addsub: three-stage WIDTH-bit adder/subtractor with valid/ready.
//   CLK, RST_          - clock, async active-low reset
//   in_valid/in_ready  - operand handshake (in_ready = !out_valid | out_ready)
//   A, B, Sub          - operands; Sub=1 computes A-B
//   out_valid/out_ready- result handshake
//   S, Cout, Ovf       - result, carry out (no-borrow on subtract), signed overflow
// Build option ADDSUB_SAT_EN: saturate S to the signed limits on overflow.
module pipelined_pg_addsub
   import addsub_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST_,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf
);

   // Global stall: every stage advances together or holds together.
   logic en_c;
   assign en_c     = !out_valid | out_ready;
   assign in_ready = en_c;

   // Stage 1 inputs: lower-bit P/G; the MSB pair is kept as raw operand bits.
   logic [WIDTH-1:0] bx_c;
   logic [WIDTH-2:0] p_lo_c, g_lo_c;
   assign bx_c   = B ^ {WIDTH{Sub}};
   assign p_lo_c = A[WIDTH-2:0] ^ bx_c[WIDTH-2:0];
   assign g_lo_c = A[WIDTH-2:0] & bx_c[WIDTH-2:0];

   logic             v1, c0_1, a_msb1, bx_msb1;
   logic [WIDTH-2:0] p1, g1;

   // Stage 2: rebuild MSB P/G and resolve all carries.
   logic [WIDTH-1:0] p_full_c, g_full_c;
   logic [WIDTH:1]   carry_c;
   assign p_full_c = {a_msb1 ^ bx_msb1, p1};
   assign g_full_c = {a_msb1 & bx_msb1, g1};

   pg_prefix_tree #(.WIDTH(WIDTH)) u_tree (
      .g     (g_full_c),
      .p     (p_full_c),
      .cin   (c0_1),
      .carry (carry_c)
   );

   logic             v2;
   logic [WIDTH:0]   c2;   // c2[0] is the carry-in, needed for S[0]
   logic [WIDTH-1:0] p2;

   // Stage 3: sum, flags and optional saturation.
   logic [WIDTH-1:0] s_c;
   logic             ovf_c;
   assign ovf_c = c2[WIDTH] ^ c2[WIDTH-1];

`ifdef ADDSUB_SAT_EN
   localparam logic [WIDTH-1:0] SAT_P = WIDTH'(SAT_POS(WIDTH));
   localparam logic [WIDTH-1:0] SAT_N = WIDTH'(SAT_NEG(WIDTH));
   // On overflow the carry out gives the true sign: 0 means positive.
   always_comb begin
      s_c = p2 ^ c2[WIDTH-1:0];
      if (ovf_c) s_c = c2[WIDTH] ? SAT_N : SAT_P;
   end
`else
   assign s_c = p2 ^ c2[WIDTH-1:0];
`endif

   // Pipeline registers; data loads on any advance, validity comes from the valid bits.
   always_ff @(posedge CLK or negedge RST_) begin
      if (!RST_) begin
         v1        <= 1'b0;
         p1        <= '0;
         g1        <= '0;
         c0_1      <= 1'b0;
         a_msb1    <= 1'b0;
         bx_msb1   <= 1'b0;
         v2        <= 1'b0;
         c2        <= '0;
         p2        <= '0;
         out_valid <= 1'b0;
         S         <= '0;
         Cout      <= 1'b0;
         Ovf       <= 1'b0;
      end else if (en_c) begin
         v1        <= in_valid;
         p1        <= p_lo_c;
         g1        <= g_lo_c;
         c0_1      <= Sub;
         a_msb1    <= A[WIDTH-1];
         bx_msb1   <= bx_c[WIDTH-1];
         v2        <= v1;
         c2        <= {carry_c, c0_1};
         p2        <= p_full_c;
         out_valid <= v2;
         S         <= s_c;
         Cout      <= c2[WIDTH];
         Ovf       <= ovf_c;
      end
   end

endmodule

// File: tb/tb_pipelined_pg_addsub.sv
// tb_pipelined_pg_addsub: directed + random checks of pipelined_pg_addsub
// against an arithmetic reference model (8-bit and 13-bit instances).
module tb_pipelined_pg_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
   logic [7:0] a, b, s;

   logic        in_valid13, in_ready13, sub13, out_valid13, out_ready13, cout13, ovf13;
   logic [12:0] a13, b13, s13;

   pipelined_pg_addsub #(.WIDTH(8)) dut (
      .CLK(clk), .RST_(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .Sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .S(s), .Cout(cout), .Ovf(ovf)
   );

   pipelined_pg_addsub #(.WIDTH(13)) dut13 (
      .CLK(clk), .RST_(rst_n), .in_valid(in_valid13), .in_ready(in_ready13),
      .A(a13), .B(b13), .Sub(sub13), .out_valid(out_valid13), .out_ready(out_ready13),
      .S(s13), .Cout(cout13), .Ovf(ovf13)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] exp;
      int          acc_cyc;
   } ent_t;
   ent_t        q[$];
   bit          lat_chk = 1'b0;
   int          n_out = 0;
   logic [31:0] last_res = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: {ovf, cout, s[15:0]} from signed/unsigned integer arithmetic.
   function automatic logic [31:0] model(input int w, input int ai, input int bi, input bit sb);
      int modv, half, sa, sbv, raw, res, sv;
      bit c, o;
      modv = 1 << w;
      half = 1 << (w - 1);
      sa   = (ai >= half) ? ai - modv : ai;
      sbv  = (bi >= half) ? bi - modv : bi;
      if (sb) begin
         raw = ai - bi;
         c   = (ai >= bi);
         res = sa - sbv;
      end else begin
         raw = ai + bi;
         c   = (raw >= modv);
         res = sa + sbv;
      end
      sv = ((raw % modv) + modv) % modv;
      o  = (res > half - 1) || (res < -half);
`ifdef ADDSUB_SAT_EN
      if (o) sv = (res > 0) ? half - 1 : half;
`endif
      return 32'(sv) | (32'(c) << 16) | (32'(o) << 17);
   endfunction

   // One cycle on the 8-bit DUT: score transfers at the negedge, then step past the next posedge.
   task automatic tick();
      ent_t e;
      logic [31:0] obs;
      @(negedge clk);
      if (out_valid && out_ready) begin
         obs = {14'b0, ovf, cout, 8'h00, s};
         last_res = obs;
         n_out++;
         if (q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
         else begin
            e = q.pop_front();
            chk("result_vs_model", obs, e.exp);
            if (lat_chk) chk("latency", 32'(cyc - e.acc_cyc), 32'd3);
         end
      end
      if (in_valid && in_ready)
         q.push_back('{exp: model(8, int'(a), int'(b), sub), acc_cyc: cyc});
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 12 && q.size() != 0; i++) tick();
      chk(tag, 32'(q.size()), 32'd0);
   endtask

   task automatic directed(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic sv, input logic [31:0] exp);
      a = av; b = bv; sub = sv; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      drain({tag, "_done"});
      chk(tag, last_res, exp);
   endtask

   task automatic one13(input string tag, input logic [12:0] av, input logic [12:0] bv,
                        input logic sv, input logic [31:0] exp);
      a13 = av; b13 = bv; sub13 = sv; in_valid13 = 1'b1;
      @(posedge clk); #1;
      in_valid13 = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_not_yet"}, 32'(out_valid13), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_valid"}, 32'(out_valid13), 32'd1);
      chk(tag, {14'b0, ovf13, cout13, 3'b000, s13}, exp);
   endtask

   logic [31:0] held;
   int          drained;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
      in_valid13 = 1'b0; a13 = '0; b13 = '0; sub13 = 1'b0; out_ready13 = 1'b1;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset state
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_flags_s", {14'b0, ovf, cout, 8'h00, s}, 32'd0);
      chk("reset_in_ready13", 32'(in_ready13), 32'd1);

      // Directed corner cases
      lat_chk = 1'b1;
`ifdef ADDSUB_SAT_EN
      directed("add_7f_01", 8'h7F, 8'h01, 1'b0, 32'h2_007F);
      directed("sub_00_01", 8'h00, 8'h01, 1'b1, 32'h0_00FF);
      directed("sub_80_01", 8'h80, 8'h01, 1'b1, 32'h3_0080);
`else
      directed("add_7f_01", 8'h7F, 8'h01, 1'b0, 32'h2_0080);
      directed("sub_00_01", 8'h00, 8'h01, 1'b1, 32'h0_00FF);
      directed("sub_80_01", 8'h80, 8'h01, 1'b1, 32'h3_007F);
`endif

      // Streaming: 20 random beats, full throughput, alternating-style random Sub
      n_out = 0;
      for (int i = 0; i < 20; i++) begin
         a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      drain("stream_drain");
      chk("stream_count", 32'(n_out), 32'd20);

      // Backpressure: fill with out_ready low, hold 5 cycles, then release
      lat_chk = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); in_valid = 1'b1;
         tick();
      end
      chk("bp_resident", 32'(q.size()), 32'd3);
      held = q[0].exp;
      for (int i = 0; i < 5; i++) begin
         a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
         tick();
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_frozen", {14'b0, ovf, cout, 8'h00, s}, held);
      end
      chk("bp_no_extra_accept", 32'(q.size()), 32'd3);
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_out = 0;
      drain("bp_drain");
      chk("bp_drain_count", 32'(n_out), 32'd3);
      drained = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (out_valid) drained++;
      end
      chk("bp_no_duplicate", 32'(drained), 32'd0);

      // Reset mid-stream with 3 beats in flight
      for (int i = 0; i < 3; i++) begin
         a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset_out_valid", 32'(out_valid), 32'd0);
      chk("async_reset_outputs", {14'b0, ovf, cout, 8'h00, s}, 32'd0);
      chk("async_reset_in_ready", 32'(in_ready), 32'd1);
      q.delete();
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_out_valid", 32'(out_valid), 32'd0);
      lat_chk = 1'b1;
      directed("after_reset_0f_01", 8'h0F, 8'h01, 1'b0, 32'h0_0010);

      // Odd width
      one13("w13_1fff_0001", 13'h1FFF, 13'h0001, 1'b0, 32'h1_0000);
      for (int i = 0; i < 4; i++) begin
         logic [12:0] ra, rb;
         logic        rs;
         ra = 13'($urandom); rb = 13'($urandom); rs = 1'($urandom);
         one13("w13_random", ra, rb, rs, model(13, int'(ra), int'(rb), rs));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
